// File: rtl/instr_queue.sv
// Thumb prefetch queue: circular halfword buffer feeding decode, with BL
// prefix/suffix merging and a single-cycle branch flush.
module instr_queue #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [31:0]   in_index,
    input  logic [15:0]   in_data,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_instr,
    output logic [31:0]   out_index,
    output logic          out_pair,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   data_q  [DEPTH];
    logic [31:0]   index_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] next_ptr;
    logic [15:0]   head_data, next_data;
    logic [31:0]   head_index, next_index;
    logic          head_prefix, pair_ok;
    logic          push, pop;
    logic [CW-1:0] pop_amt;

    assign next_ptr   = head_q + PW'(1);
    assign head_data  = data_q[head_q];
    assign next_data  = data_q[next_ptr];
    assign head_index = index_q[head_q];
    assign next_index = index_q[next_ptr];

    // A full queue always holds head+1, so a prefix at head can never stall forever.
    assign head_prefix = (count_q != '0) && (head_data[15:11] == 5'b11110);
    assign pair_ok     = head_prefix && (count_q >= CW'(2)) &&
                         (next_data[15:11] == 5'b11111) &&
                         (next_index == head_index + 32'd1);

    assign in_ready  = (count_q < FULL);
    assign out_valid = (count_q != '0) && !(head_prefix && (count_q == CW'(1)));
    assign out_pair  = out_valid && pair_ok;
    assign out_index = out_valid ? head_index : 32'd0;
    assign count     = count_q;

    always_comb begin
        out_instr = 32'd0;
        if (out_valid) begin
            out_instr = pair_ok ? {next_data, head_data} : {16'h0000, head_data};
        end
    end

    assign push    = in_valid && in_ready && !flush && !reset;
    assign pop     = out_valid && out_ready && !flush && !reset;
    assign pop_amt = pop ? (pair_ok ? CW'(2) : CW'(1)) : CW'(0);

    always_comb begin
        head_d  = head_q + pop_amt[PW-1:0];
        tail_d  = tail_q + (push ? PW'(1) : PW'(0));
        count_d = count_q + (push ? CW'(1) : CW'(0)) - pop_amt;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q]  <= in_data;
            index_q[tail_q] <= in_index;
        end
    end

endmodule

// File: doc/instr_queue.md
# instr_queue

Prefetch queue between the instruction cache and the Thumb decode stage. Buffers 16-bit halfwords returned by the icache together with their halfword index and presents them to decode through a valid/ready handshake. Merges a BL prefix/suffix pair into a single 32-bit instruction and discards all buffered content on a branch flush.

## Interface

- DEPTH, 4, number of halfword entries; power of two, at least 2.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; dominates every other input.
- flush  in  1  branch redirect; empties the queue.
- in_valid  in  1  icache halfword present this cycle.
- in_index  in  32  halfword index of in_data.
- in_data  in  16  Thumb halfword.
- in_ready  out  1  queue accepts a push this cycle.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes the presented instruction.
- out_instr  out  32  {suffix, prefix} for a pair, {16'h0000, halfword} otherwise.
- out_index  out  32  index of the first (or only) halfword.
- out_pair  out  1  out_instr is a merged BL pair.
- count  out  $clog2(DEPTH)+1  number of occupied entries.

## Operation

- Circular buffer of DEPTH entries {data[15:0], index[31:0]} with head/tail pointers and a registered count.
- Push: in_valid && in_ready && !flush writes at tail; tail advances and wraps modulo DEPTH.
- in_ready = (count < DEPTH), taken from registered count; a pop in the same cycle does not free a slot for that cycle. If in_valid is high while in_ready is 0, nothing is written and no state changes.
- Head classification: prefix = data[15:11]==5'b11110; suffix = data[15:11]==5'b11111.
- Presentation rules, evaluated combinationally from the stored entries:
  - Head is not a prefix (including a lone suffix): out_valid=1, out_pair=0, single-entry pop.
  - Head is a prefix and count==1: out_valid=0; wait for the next halfword.
  - Head is a prefix and entry head+1 is a suffix with index == head.index+1 (mod 2^32): out_valid=1, out_pair=1, out_instr={entry1.data, head.data}, two-entry pop.
  - Head is a prefix and entry head+1 is a non-suffix, or its index is not consecutive: emit the prefix alone, out_pair=0, single-entry pop.
- Pop: out_valid && out_ready removes 1 or 2 entries, as selected above.
- A push and a pop in the same cycle are allowed; count changes by +1-1, +1-2, or the single term that applies.
- When out_valid=0, out_instr, out_index and out_pair are driven to 0.
- Flush: head, tail and count return to 0 next cycle. A push or pop in the flush cycle is discarded. No instruction is presented to decode as consumed in that cycle, even if out_ready=1.
- Reset: same as flush, and also takes priority over flush.

## Timing

- Reset values: count=0, in_ready=1, out_valid=0, out_instr=0, out_index=0, out_pair=0.
- Latency: a halfword accepted at edge N is visible on out_* after edge N; there is no same-cycle bypass from in_data to out_instr.
- BL pair: out_valid rises in the cycle after the suffix is accepted.
- Throughput: one instruction per cycle while non-empty; a pair consumes two entries in one pop.
- Full (count==DEPTH) with a prefix at head: entry head+1 always exists, so the block cannot deadlock.
- Pointer wrap: the second entry of a pair may sit at physical slot 0 while the head sits at slot DEPTH-1; it must merge normally.
- Index wrap: in_index 32'hFFFFFFFF followed by 32'h00000000 counts as consecutive.

## Test plan

- Reset, then push 0x2001 @10, 0x3002 @11 with out_ready=1 -> out_instr 0x00002001/idx 10, then 0x00003002/idx 11 on consecutive cycles; count returns to 0; out_* read 0 when idle.
- out_ready=0, push five halfwords -> in_ready falls after the fourth push, count=4, fifth halfword not stored; out_ready=1 drains exactly the first four, in order.
- Push 0xF000 @20, idle one cycle, then push 0xF802 @21 -> out_valid stays 0 until the suffix is stored, then a single beat out_instr=0xF802F000, out_pair=1, idx 20, count 2->0.
- Push 0xF000 @30, then 0x4770 @31 -> two beats: 0x0000F000 (pair=0), then 0x00004770; same result for 0xF000 @30 followed by 0xF802 @33.
- Fill 3 entries, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, in_ready=1; the next push @40 appears first.
- Assert reset with flush and the queue full -> all reset values next cycle. Separately, a pair straddling slot 3→0 with indexes 0xFFFFFFFF/0x0 -> merged, out_pair=1.
